// File: rtl/jt10_adpcm_sched.sv
// ADPCM-A channel scheduler: 6-slot rotation, frame match strobe, key on/off mask
// and a one-entry-per-channel L/R/level update queue. Optional macro: JT10_ADPCM_SCHED_FLAGS_EN.
module jt10_adpcm_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cfg_wr,
    input  logic [4:0] cfg_addr,
    input  logic [7:0] cfg_din,
    input  logic       ch_end,
    output logic [5:0] cur_ch,
    output logic [5:0] en_ch,
    output logic       match,
    output logic [5:0] atl,
    output logic [7:0] lracl,
    output logic [2:0] up_ch,
    output logic [5:0] flags
);

    logic [2:0] round;
    logic [5:0] pend;
    logic [5:0] pend_nxt;
    logic [5:0] head_oh;
    logic [5:0] en_nxt;
    logic [5:0] wr_lr;
    logic [7:0] shadow [0:5];
    logic       wr_key;
    logic       wr_atl;

    assign wr_key = cfg_wr && (cfg_addr == 5'h00);
    assign wr_atl = cfg_wr && (cfg_addr == 5'h01);

    always_comb begin
        for (int i = 0; i < 6; i++)
            wr_lr[i] = cfg_wr && (cfg_addr == 5'(i + 8));
    end

    // Lowest pending channel is the queue head
    assign head_oh = pend & (~pend + 6'd1);

    always_comb begin
        up_ch = 3'd7;
        lracl = 8'd0;
        for (int i = 5; i >= 0; i--) begin
            if (pend[i]) begin
                up_ch = 3'(i);
                lracl = shadow[i];
            end
        end
    end

    // A write landing on the consuming edge re-arms the entry
    always_comb begin
        pend_nxt = pend;
        if (cen)
            pend_nxt = pend_nxt & ~(cur_ch & head_oh);
        pend_nxt = pend_nxt | wr_lr;
    end

    // Key-on is applied after ch_end so it wins on the same channel
    always_comb begin
        en_nxt = en_ch;
        if (cen && ch_end)
            en_nxt = en_nxt & ~cur_ch;
        if (wr_key)
            en_nxt = cfg_din[7] ? (en_nxt & ~cfg_din[5:0]) : (en_nxt | cfg_din[5:0]);
    end

    assign match = (round == 3'd0) && |(en_ch & cur_ch);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_ch <= 6'b000001;
            round  <= 3'd0;
            en_ch  <= 6'd0;
            atl    <= 6'd0;
            pend   <= 6'd0;
            for (int i = 0; i < 6; i++)
                shadow[i] <= 8'd0;
        end else begin
            if (cen) begin
                cur_ch <= {cur_ch[4:0], cur_ch[5]};
                if (cur_ch[5])
                    round <= (round == 3'd5) ? 3'd0 : round + 3'd1;
            end
            en_ch <= en_nxt;
            pend  <= pend_nxt;
            if (wr_atl)
                atl <= cfg_din[5:0];
            for (int i = 0; i < 6; i++)
                if (wr_lr[i])
                    shadow[i] <= cfg_din;
        end
    end

`ifdef JT10_ADPCM_SCHED_FLAGS_EN
    logic [5:0] flg_nxt;
    logic       wr_fclr;

    assign wr_fclr = cfg_wr && (cfg_addr == 5'h1C);

    always_comb begin
        flg_nxt = flags;
        if (cen && ch_end)
            flg_nxt = flg_nxt | cur_ch;
        if (wr_key && !cfg_din[7])
            flg_nxt = flg_nxt & ~cfg_din[5:0];
        if (wr_fclr)
            flg_nxt = flg_nxt & ~cfg_din[5:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            flags <= 6'd0;
        else
            flags <= flg_nxt;
    end
`else
    assign flags = 6'd0;
`endif

endmodule
